// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS bit-alignment datapath: word format,
// training pattern and the training sequencer's state encoding.
package lvds_pkg;

    localparam int WORD_W  = 12;
    localparam int RETRY_W = 4;

    // Also used by the bit aligner, so both ends agree on the pattern.
    localparam logic [WORD_W-1:0] TP_DEFAULT = 12'hA5B;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_RESET_ALIGN = 3'd1;
    localparam logic [2:0] S_WAIT_ACK    = 3'd2;
    localparam logic [2:0] S_VERIFY      = 3'd3;
    localparam logic [2:0] S_RETRY       = 3'd4;
    localparam logic [2:0] S_LOCKED      = 3'd5;
    localparam logic [2:0] S_FAIL        = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE        = S_IDLE,
        ST_RESET_ALIGN = S_RESET_ALIGN,
        ST_WAIT_ACK    = S_WAIT_ACK,
        ST_VERIFY      = S_VERIFY,
        ST_RETRY       = S_RETRY,
        ST_LOCKED      = S_LOCKED,
        ST_FAIL        = S_FAIL
    } train_state_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lvds_train_ctrl_if.sv
// Handshake/status bundle between the training sequencer and its environment.
// err_cnt exists only when TRAIN_ERR_CNT_EN is defined.
interface lvds_train_ctrl_if;
    import lvds_pkg::*;

    logic              start;
    logic              align_ack;
    logic              word_stb;
    logic [WORD_W-1:0] word_in;
    logic              align_rst;
    logic              adc_test_mode;
    logic              locked;
    logic              fail;
    logic              busy;
    logic [RETRY_W-1:0] retry_cnt;
    logic [2:0]        state_o;
`ifdef TRAIN_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    modport master (
        output start, align_ack, word_stb, word_in,
`ifdef TRAIN_ERR_CNT_EN
        input  err_cnt,
`endif
        input  align_rst, adc_test_mode, locked, fail, busy, retry_cnt, state_o
    );

    modport slave (
        input  start, align_ack, word_stb, word_in,
`ifdef TRAIN_ERR_CNT_EN
        output err_cnt,
`endif
        output align_rst, adc_test_mode, locked, fail, busy, retry_cnt, state_o
    );

endinterface

// File: rtl/lvds_train_timer.sv
// Up-counting cycle timer with synchronous clear, enable and a terminal-count
// flag; it holds at the terminal value instead of wrapping.
module lvds_train_timer #(
    parameter int W = 10
) (
    input  logic         CLK_IN,
    input  logic         RST_N,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/lvds_train_ctrl.sv
// LVDS link-training sequencer: aligner reset, ack wait, pattern verify, retry.
// Optional err_cnt output is built when TRAIN_ERR_CNT_EN is defined.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | untrained, aligner held in reset, waiting for start
// RESET_ALIGN  | aligner held in reset for RST_CYC cycles, ADC sends TP
// WAIT_ACK     | aligner released, waiting for align_ack (bounded)
// VERIFY       | counting consecutive TP words (first strobe discarded)
// RETRY        | one cycle: retry again or give up
// LOCKED       | link trained; loss of ack or start retrains
// FAIL         | retries exhausted, held until start or reset
module lvds_train_ctrl
    import lvds_pkg::*;
#(
    parameter logic [WORD_W-1:0] TP          = TP_DEFAULT,
    parameter int                RST_CYC     = 16,
    parameter int                ACK_TIMEOUT = 1024,
    parameter int                MATCH_WORDS = 8,
    parameter int                MAX_RETRY   = 3
) (
    input  logic              CLK_IN,
    input  logic              RST_N,
    lvds_train_ctrl_if.slave  bus
);

    localparam int TMR_W   = cnt_w(((ACK_TIMEOUT > RST_CYC) ? ACK_TIMEOUT : RST_CYC) - 1);
    localparam int MATCH_W = cnt_w(MATCH_WORDS);

    train_state_t         state, state_nxt;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic                 discard_q, discard_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 align_rst_q, train_act_q, locked_q, fail_q;
    logic                 err_evt, err_clr;
    logic                 word_ok, word_taken;
    logic                 tmr_clr, tmr_en, tmr_tc;
    logic [TMR_W-1:0]     tmr_tc_val;

    assign tmr_clr    = (state_nxt != state);
    assign tmr_en     = (state == ST_RESET_ALIGN) || (state == ST_WAIT_ACK) || (state == ST_VERIFY);
    assign tmr_tc_val = (state == ST_RESET_ALIGN) ? TMR_W'(RST_CYC - 1) : TMR_W'(ACK_TIMEOUT - 1);

    lvds_train_timer #(.W(TMR_W)) u_timer (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .tc_val (tmr_tc_val),
        .tc     (tmr_tc)
    );

    assign word_ok    = (bus.word_in == TP);
    assign word_taken = bus.word_stb && !discard_q;

    always_comb begin
        state_nxt = state;
        match_d   = match_q;
        discard_d = discard_q;
        retry_d   = retry_q;
        err_evt   = 1'b0;
        err_clr   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    retry_d   = '0;
                    err_clr   = 1'b1;
                    state_nxt = ST_RESET_ALIGN;
                end
            end
            ST_RESET_ALIGN: begin
                if (tmr_tc) state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.align_ack) begin
                    match_d   = '0;
                    discard_d = 1'b1;
                    state_nxt = ST_VERIFY;
                end else if (tmr_tc) begin
                    err_evt   = 1'b1;
                    state_nxt = ST_RETRY;
                end
            end
            ST_VERIFY: begin
                if (bus.word_stb && discard_q) begin
                    discard_d = 1'b0;
                end else if (word_taken && word_ok) begin
                    match_d = match_q + 1'b1;
                end
                // A lock-completing word beats a coincident timeout or ack loss.
                if (word_taken && word_ok && match_q == MATCH_W'(MATCH_WORDS - 1)) begin
                    state_nxt = ST_LOCKED;
                end else if (word_taken && !word_ok) begin
                    err_evt   = 1'b1;
                    state_nxt = ST_RETRY;
                end else if (!bus.align_ack) begin
                    state_nxt = ST_RETRY;
                end else if (tmr_tc) begin
                    err_evt   = 1'b1;
                    state_nxt = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (retry_q == RETRY_W'(MAX_RETRY)) begin
                    state_nxt = ST_FAIL;
                end else begin
                    retry_d   = retry_q + 1'b1;
                    state_nxt = ST_RESET_ALIGN;
                end
            end
            ST_LOCKED: begin
                if (bus.start) begin
                    retry_d   = '0;
                    err_clr   = 1'b1;
                    state_nxt = ST_RESET_ALIGN;
                end else if (!bus.align_ack) begin
                    retry_d   = '0;
                    state_nxt = ST_RESET_ALIGN;
                end
            end
            ST_FAIL: begin
                if (bus.start) begin
                    retry_d   = '0;
                    err_clr   = 1'b1;
                    state_nxt = ST_RESET_ALIGN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            match_q     <= '0;
            discard_q   <= 1'b0;
            retry_q     <= '0;
            align_rst_q <= 1'b1;
            train_act_q <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            match_q     <= match_d;
            discard_q   <= discard_d;
            retry_q     <= retry_d;
            // Outputs are registered from the next state so they line up with state_o.
            align_rst_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET_ALIGN) ||
                           (state_nxt == ST_FAIL);
            train_act_q <= (state_nxt == ST_RESET_ALIGN) || (state_nxt == ST_WAIT_ACK) ||
                           (state_nxt == ST_VERIFY) || (state_nxt == ST_RETRY);
            locked_q    <= (state_nxt == ST_LOCKED);
            fail_q      <= (state_nxt == ST_FAIL);
        end
    end

    assign bus.align_rst     = align_rst_q;
    assign bus.adc_test_mode = train_act_q;
    assign bus.busy          = train_act_q;
    assign bus.locked        = locked_q;
    assign bus.fail          = fail_q;
    assign bus.retry_cnt     = retry_q;
    assign bus.state_o       = state;

`ifdef TRAIN_ERR_CNT_EN
    logic [7:0] err_q;

    always_ff @(posedge CLK_IN) begin
        if (!RST_N || err_clr) begin
            err_q <= '0;
        end else if (err_evt && err_q != 8'hFF) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign bus.err_cnt = err_q;
`else
    logic unused_err;
    assign unused_err = err_evt | err_clr;
`endif

endmodule

// File: tb/tb_lvds_train_ctrl.sv
// Randomized self-checking bench for lvds_train_ctrl with an attempt-level
// model of training outcomes (retries, fail, lock, error count).
module tb_lvds_train_ctrl;

    localparam logic [11:0] TP          = 12'hA5B;
    localparam int          RST_CYC     = 16;
    localparam int          ACK_TIMEOUT = 1024;
    localparam int          MATCH_WORDS = 8;
    localparam int          MAX_RETRY   = 3;

    localparam int K_GOOD = 0, K_BAD = 1, K_TMO = 2, K_ACKLOSS = 3, K_RST = 4;

    logic CLK_IN = 1'b0;
    logic RST_N  = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fails_exp = 0;
    int   err_exp   = 0;
    bit   lk;

    lvds_train_ctrl_if bus();

    lvds_train_ctrl #(
        .TP(TP), .RST_CYC(RST_CYC), .ACK_TIMEOUT(ACK_TIMEOUT),
        .MATCH_WORDS(MATCH_WORDS), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .bus    (bus)
    );

    always #5 CLK_IN = ~CLK_IN;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic noise();
        bus.start    = ($urandom_range(0, 7) == 0);
        bus.word_stb = $urandom_range(0, 1);
        bus.word_in  = ($urandom_range(0, 1) == 1) ? TP : 12'($urandom);
    endtask

    task automatic quiet();
        bus.start    = 1'b0;
        bus.word_stb = 1'b0;
    endtask

    task automatic err_bump();
        err_exp = (err_exp < 255) ? err_exp + 1 : 255;
    endtask

    task automatic chk_err(input string tag);
`ifdef TRAIN_ERR_CNT_EN
        chk(tag, bus.err_cnt, err_exp);
`endif
    endtask

    task automatic chk_outs(input string tag, input int st, input int ar, input int adc,
                            input int lkd, input int fl, input int bz, input int rc);
        chk({tag, ".state"},     bus.state_o,       st);
        chk({tag, ".align_rst"}, bus.align_rst,     ar);
        chk({tag, ".adc_test"},  bus.adc_test_mode, adc);
        chk({tag, ".locked"},    bus.locked,        lkd);
        chk({tag, ".fail"},      bus.fail,          fl);
        chk({tag, ".busy"},      bus.busy,          bz);
        chk({tag, ".retry_cnt"}, bus.retry_cnt,     rc);
    endtask

    task automatic do_start();
        bus.align_ack = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        fails_exp = 0;
        err_exp   = 0;
        chk_outs("start", 1, 1, 1, 0, 0, 1, 0);
        chk_err("start.err");
    endtask

    task automatic loss_of_lock();
        bus.align_ack = 1'b0;
        tick();
        fails_exp = 0;
        chk_outs("lol", 1, 1, 1, 0, 0, 1, 0);
        chk_err("lol.err");
    endtask

    // Entered on the first cycle of RESET_ALIGN; runs one aligner attempt.
    task automatic attempt(input int kind, input int k, output bit got_lock);
        int n;
        got_lock = 1'b0;
        n = 0;
        while (bus.align_rst && n < 100) begin
            noise();
            tick();
            n++;
        end
        quiet();
        chk("align_rst_len", n, RST_CYC);
        chk("wait.state", bus.state_o, 2);
        if (kind == K_TMO) begin
            n = 0;
            while (bus.state_o == 2 && n < ACK_TIMEOUT + 50) begin
                noise();
                tick();
                n++;
            end
            quiet();
            chk("ack_wait_len", n, ACK_TIMEOUT);
            err_bump();
            return;
        end
        repeat ($urandom_range(0, 40)) begin
            noise();
            tick();
        end
        quiet();
        bus.align_ack = 1'b1;
        tick();
        chk("verify.state", bus.state_o, 3);
        for (int i = 0; i <= MATCH_WORDS; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            if (kind == K_ACKLOSS && i == k) begin
                bus.align_ack = 1'b0;
                tick();
                return;
            end
            bus.word_stb = 1'b1;
            if (i == 0)
                bus.word_in = 12'($urandom);
            else if (kind == K_BAD && i == k)
                bus.word_in = TP ^ (12'd1 << $urandom_range(0, 11));
            else
                bus.word_in = TP;
            tick();
            bus.word_stb = 1'b0;
            bus.word_in  = 12'($urandom);
            if (kind == K_BAD && i == k) begin
                err_bump();
                return;
            end
            if (kind == K_RST && i == 4) begin
                RST_N = 1'b0;
                tick();
                RST_N = 1'b1;
                bus.align_ack = 1'b0;
                fails_exp = 0;
                err_exp   = 0;
                chk_outs("midreset", 0, 1, 0, 0, 0, 0, 0);
                chk_err("midreset.err");
                return;
            end
            if (i < MATCH_WORDS) chk("verify.hold", bus.state_o, 3);
        end
        got_lock = 1'b1;
    endtask

    task automatic after_fail(output bit done);
        fails_exp++;
        bus.align_ack = 1'b0;
        chk("retry.state", bus.state_o, 4);
        chk("retry.rc", bus.retry_cnt, fails_exp - 1);
        chk("retry.busy", bus.busy, 1);
        tick();
        if (fails_exp > MAX_RETRY) begin
            chk_outs("exhausted", 6, 1, 0, 0, 1, 0, MAX_RETRY);
            done = 1'b1;
        end else begin
            chk_outs("realign", 1, 1, 1, 0, 0, 1, fails_exp);
            done = 1'b0;
        end
        chk_err("retry.err");
    endtask

    // mode 0: random outcomes; 1: nbad mismatches then clean; 2: never acked
    task automatic train_run(input int mode, input int nbad, input int kfix, output bit got_lock);
        int  kind;
        int  r;
        bit  done;
        got_lock = 1'b0;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            if (mode == 2) begin
                kind = K_TMO;
            end else if (mode == 1) begin
                kind = (a < nbad) ? K_BAD : K_GOOD;
            end else begin
                r = $urandom_range(0, 9);
                kind = (r == 0) ? K_TMO : (r < 3) ? K_BAD : (r == 3) ? K_ACKLOSS : K_GOOD;
            end
            attempt(kind, (kfix != 0) ? kfix : $urandom_range(1, MATCH_WORDS), got_lock);
            if (got_lock) begin
                chk_outs("lock", 5, 0, 0, 1, 0, 0, fails_exp);
                chk_err("lock.err");
                return;
            end
            after_fail(done);
            if (done) return;
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.align_ack = 1'b0;
        bus.word_stb  = 1'b0;
        bus.word_in   = '0;
        RST_N = 1'b0;
        tick();
        tick();
        chk_outs("reset", 0, 1, 0, 0, 0, 0, 0);
        chk_err("reset.err");
        RST_N = 1'b1;
        repeat (5) begin
            bus.word_stb = 1'b1;
            bus.word_in  = TP;
            tick();
        end
        quiet();
        chk("idle.state", bus.state_o, 0);

        // happy path
        do_start();
        train_run(1, 0, 0, lk);
        chk("happy.locked", lk, 1);
        repeat (10) begin
            bus.word_stb = $urandom_range(0, 1);
            bus.word_in  = 12'($urandom);
            tick();
        end
        quiet();
        chk("locked.hold", bus.state_o, 5);

        // mismatch on the third counted word, then clean
        do_start();
        train_run(1, 1, 3, lk);
        chk("mismatch.locked", lk, 1);

        // loss of lock retrains
        loss_of_lock();
        train_run(1, 0, 0, lk);

        // ack never arrives: four timed-out attempts then FAIL
        do_start();
        train_run(2, 0, 0, lk);
        chk("timeout.nolock", lk, 0);
        repeat (20) begin
            bus.align_ack = $urandom_range(0, 1);
            bus.word_stb  = $urandom_range(0, 1);
            tick();
        end
        quiet();
        bus.align_ack = 1'b0;
        chk("fail.hold.state", bus.state_o, 6);
        chk("fail.hold.fail", bus.fail, 1);
        do_start();
        train_run(1, 0, 0, lk);

        // reset after four matches; fresh start must need a full set of matches
        do_start();
        attempt(K_RST, 0, lk);
        do_start();
        train_run(1, 0, 0, lk);

`ifdef TRAIN_ERR_CNT_EN
        do_start();
        train_run(1, 2, 0, lk);
        chk("err.two", bus.err_cnt, 2);
`endif

        // random campaign
        repeat (15) begin
            if (lk && $urandom_range(0, 1) == 1) loss_of_lock();
            else do_start();
            train_run(0, 0, 0, lk);
        end

`ifdef TRAIN_ERR_CNT_EN
        do_start();
        train_run(1, 0, 0, lk);
        repeat (90) begin
            loss_of_lock();
            train_run(1, MAX_RETRY, 0, lk);
        end
        chk("err.saturated", bus.err_cnt, 255);
`else
        $display("[TB] note: err_cnt not built, %0d modelled error events", err_exp);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lvds_train_ctrl.md
Name: lvds_train_ctrl

Overview:
Link-training sequencer for the LVDS bit-alignment datapath. It puts the ADC into training-pattern mode and holds the bit aligner in reset for a fixed time. It then releases the aligner, waits for its alignment acknowledge, and checks a run of consecutive 12-bit words against the training pattern. On success it declares lock; on failure it retries a bounded number of times and then reports failure.

Parameters:
TP, 12'hA5B, expected training pattern word
RST_CYC, 16, cycles align_rst is held high per attempt
ACK_TIMEOUT, 1024, max cycles in WAIT_ACK or VERIFY before the attempt is abandoned
MATCH_WORDS, 8, consecutive matching words required for lock
MAX_RETRY, 3, retries after the first attempt before FAIL

Ports:
CLK_IN  in  1  system clock; all logic is on its rising edge
RST_N  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse that begins or restarts training
align_ack  in  1  alignment-verified level from the bit aligner
word_stb  in  1  one-cycle strobe, new 12-bit word valid (CLK_IN domain)
word_in  in  12  deserialized word, valid when word_stb=1
align_rst  out  1  drives the aligner's active-high reset input
adc_test_mode  out  1  requests the ADC to transmit TP
locked  out  1  link trained, data path usable
fail  out  1  training exhausted all retries
busy  out  1  training in progress
retry_cnt  out  4  retries consumed in the current training run
state_o  out  3  current state encoding (debug)

Behaviour:
- Reset (RST_N=0 at an edge):
  - Reset has priority over all other inputs.
  - Next-cycle values: state IDLE, align_rst=1, adc_test_mode=0, locked=0, fail=0, busy=0, retry_cnt=0, timer=0, match=0.
- Outputs: all registered. State encoding: IDLE=0, RESET_ALIGN=1, WAIT_ACK=2, VERIFY=3, RETRY=4, LOCKED=5, FAIL=6.
- IDLE:
  - align_rst=1; start is the only exit.
  - On start: retry_cnt=0, adc_test_mode=1, busy=1, timer=0, go to RESET_ALIGN.
- RESET_ALIGN:
  - align_rst=1 for exactly RST_CYC cycles.
  - Then align_rst=0, timer=0, go to WAIT_ACK.
- WAIT_ACK:
  - align_ack=1: go to VERIFY with match=0, timer=0, discard_first=1.
  - Timer reaches ACK_TIMEOUT-1 with no ack: go to RETRY.
- VERIFY:
  - The first word_stb after entry is discarded (may be a partial word).
  - On each later word_stb: word_in==TP gives match+1; when match reaches MATCH_WORDS, go to LOCKED.
  - word_in!=TP, align_ack falling to 0, or timer reaching ACK_TIMEOUT-1: go to RETRY.
  - If the lock-completing word and timeout occur in the same cycle, LOCKED wins.
- RETRY (one cycle):
  - If retry_cnt==MAX_RETRY: go to FAIL.
  - Otherwise retry_cnt+1, align_rst=1, go to RESET_ALIGN.
- LOCKED:
  - locked=1, busy=0, adc_test_mode=0, align_rst=0.
  - align_ack=0: locked=0 next cycle, retry_cnt=0, adc_test_mode=1, busy=1, go to RESET_ALIGN.
  - start: same restart path.
- FAIL:
  - fail=1, align_rst=1, adc_test_mode=0, busy=0.
  - Held until start (fail cleared, restart as from IDLE) or reset.
- start is ignored in RESET_ALIGN, WAIT_ACK, VERIFY and RETRY.
- word_stb is ignored outside VERIFY.
- Counters:
  - timer: sized for ACK_TIMEOUT; never wraps, since the state exits at terminal count.
  - match: sized for MATCH_WORDS.
  - retry_cnt: saturates at MAX_RETRY.

Optional Feature:
TRAIN_ERR_CNT_EN
- Defined: adds output err_cnt[7:0].
  - Increments once per mismatched word in VERIFY and once per timeout (WAIT_ACK or VERIFY).
  - Saturates at 255.
  - Cleared by reset and by an accepted start; unchanged by a loss-of-ack restart from LOCKED.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package lvds_pkg holds:
  - state encoding localparams;
  - default TP 12'hA5B (shared with the bit aligner);
  - word width 12;
  - retry_cnt width 4.
- One sub-module, lvds_train_timer: cycle counter with sync clear, enable and terminal-count flag. Instantiated once, reused across RESET_ALIGN, WAIT_ACK and VERIFY.

Test Plan:
1. Happy path: start; aligner model raises ack 20 cycles after align_rst falls, then sends 9 words of 0xA5B. Expect: align_rst high 16 cycles; locked=1 after the 9th word_stb; adc_test_mode=0; retry_cnt=0; busy=0.
2. Mismatch: in VERIFY, 3rd word is 0xA5A. Expect: RETRY; retry_cnt=1; align_rst high again for 16 cycles; then lock on clean words.
3. Timeout exhaustion: ack never asserted. Expect: retry after each 1024-cycle wait; fail=1 after 4 attempts with retry_cnt=3; start clears fail and retry_cnt.
4. Loss of lock: drop align_ack while LOCKED. Expect: locked=0 and adc_test_mode=1 next cycle; state RESET_ALIGN; retry_cnt=0.
5. Reset mid-VERIFY: RST_N=0 for one cycle after 4 matches. Expect all outputs at reset values next edge; a later start needs a full 8 new matches.
6. With TRAIN_ERR_CNT_EN: 2 mismatches then lock gives err_cnt=2; 300 forced mismatch retries (with MAX_RETRY raised) saturate err_cnt at 255.
